// File: rtl/codec_stream_ctrl_if.sv
// Codec / effect-chain handshake bundle for codec_stream_ctrl.
// master = the stream controller, slave = codec core plus effect chain.
interface codec_stream_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2
);
    logic                       audio_in_available;
    logic                       read_audio_in;
    logic [NUM_CH*DATA_W-1:0]   audio_in;
    logic                       audio_out_allowed;
    logic                       write_audio_out;
    logic [NUM_CH*DATA_W-1:0]   audio_out;
    logic                       mute;
    logic                       fx_tick;
    logic [NUM_CH*DATA_W-1:0]   fx_in;
    logic [NUM_CH*DATA_W-1:0]   fx_out;

    modport master (
        input  audio_in_available, audio_in, audio_out_allowed, mute, fx_out,
        output read_audio_in, write_audio_out, audio_out, fx_tick, fx_in
    );

    modport slave (
        output audio_in_available, audio_in, audio_out_allowed, mute, fx_out,
        input  read_audio_in, write_audio_out, audio_out, fx_tick, fx_in
    );
endinterface

// File: rtl/codec_stream_ctrl.sv
// Decoupled codec <-> effect-chain streaming controller with credit-limited reads,
// fixed-latency result capture and an output FIFO. CODEC_STREAM_STATS_EN adds counters.
module codec_stream_ctrl #(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int FX_LATENCY = 0
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    codec_stream_ctrl_if.master bus
`ifdef CODEC_STREAM_STATS_EN
    ,
    output logic [15:0]         underrun_cnt,
    output logic [15:0]         drop_cnt
`endif
);
    localparam int FRAME_W = NUM_CH * DATA_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef logic [FRAME_W-1:0] frame_t;
    typedef enum logic { R_IDLE, R_ACK } rd_state_e;
    typedef enum logic { W_IDLE, W_ACK } wr_state_e;

    rd_state_e        rd_state_q, rd_state_d;
    wr_state_e        wr_state_q, wr_state_d;
    frame_t           fx_in_q, fx_in_d;
    frame_t           audio_out_q, audio_out_d;
    frame_t           mem_q [FIFO_DEPTH];
    frame_t           mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W:0]   occupancy;
    logic             credit;
    logic             tick;
    logic             push;
    logic             pop;
    frame_t           push_data;

    // Frames in flight through the effect chain hold a FIFO slot in advance.
    assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
    assign credit    = occupancy < (CNT_W+1)'(FIFO_DEPTH);
    assign tick      = (rd_state_q == R_ACK);
    assign pop       = (wr_state_q == W_IDLE) && (count_q != '0) && bus.audio_out_allowed;
    assign push_data = bus.mute ? '0 : bus.fx_out;

    assign bus.read_audio_in   = tick;
    assign bus.fx_tick         = tick;
    assign bus.fx_in           = fx_in_q;
    assign bus.write_audio_out = (wr_state_q == W_ACK);
    assign bus.audio_out       = audio_out_q;

    always_comb begin
        rd_state_d = rd_state_q;
        fx_in_d    = fx_in_q;
        case (rd_state_q)
            R_IDLE: begin
                if (bus.audio_in_available && credit) begin
                    fx_in_d    = bus.audio_in;
                    rd_state_d = R_ACK;
                end
            end
            R_ACK:   rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d  = wr_state_q;
        audio_out_d = audio_out_q;
        case (wr_state_q)
            W_IDLE: begin
                if (pop) begin
                    audio_out_d = mem_q[rd_ptr_q];
                    wr_state_d  = W_ACK;
                end
            end
            W_ACK:   wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    generate
        if (FX_LATENCY == 0) begin : g_no_latency
            assign push = tick;
        end else begin : g_latency
            logic [FX_LATENCY-1:0] vpipe_q, vpipe_d;

            always_comb begin
                vpipe_d = (vpipe_q << 1) | FX_LATENCY'(tick);
            end

            always_ff @(posedge CLOCK_50 or negedge resetn) begin
                if (!resetn) vpipe_q <= '0;
                else         vpipe_q <= vpipe_d;
            end

            assign push = vpipe_q[FX_LATENCY-1];
        end
    endgenerate

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case ({tick, push})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rd_state_q  <= R_IDLE;
            wr_state_q  <= W_IDLE;
            fx_in_q     <= '0;
            audio_out_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            inflight_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            wr_state_q  <= wr_state_d;
            fx_in_q     <= fx_in_d;
            audio_out_q <= audio_out_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            mem_q       <= mem_d;
        end
    end

`ifdef CODEC_STREAM_STATS_EN
    logic        primed_q, primed_d;
    logic        und_cond_q, und_cond_d;
    logic [15:0] underrun_q, underrun_d;
    logic [15:0] drop_q, drop_d;

    // Underruns only count once output has started, and once per starvation episode.
    always_comb begin
        primed_d   = primed_q | (wr_state_q == W_ACK);
        und_cond_d = bus.audio_out_allowed && (count_q == '0) && primed_q;
        underrun_d = underrun_q;
        drop_d     = drop_q;
        if (und_cond_d && !und_cond_q && (underrun_q != '1))
            underrun_d = underrun_q + 16'd1;
        if ((rd_state_q == R_IDLE) && bus.audio_in_available && !credit && (drop_q != '1))
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            primed_q   <= 1'b0;
            und_cond_q <= 1'b0;
            underrun_q <= '0;
            drop_q     <= '0;
        end else begin
            primed_q   <= primed_d;
            und_cond_q <= und_cond_d;
            underrun_q <= underrun_d;
            drop_q     <= drop_d;
        end
    end

    assign underrun_cnt = underrun_q;
    assign drop_cnt     = drop_q;
`endif
endmodule
